// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state/enable types and the RUN-state enable/bubble decision
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} pipe_ctrl_state_e;
    typedef struct packed {
        logic pc;
        logic fd;
        logic de;
        logic em;
        logic mw;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
    } pipe_en_t;
    localparam pipe_en_t EN_FREEZE = pipe_en_t'(8'b0000_0000);
    localparam pipe_en_t EN_RESET  = pipe_en_t'(8'b0000_0111);
    // Priority: redirect flushes wrong-path D, then load-use bubble, then fetch miss.
    function automatic pipe_en_t run_rules(input logic branch, input logic stall, input logic imem);
        pipe_en_t r;
        r = pipe_en_t'(8'b1111_1000);
        if (branch) begin
            r.d_bubble = 1'b1;
            r.e_bubble = 1'b1;
        end else if (stall) begin
            r.pc = 1'b0;
            r.fd = 1'b0;
            r.de = 1'b0;
            r.m_bubble = 1'b1;
        end else if (!imem) begin
            r.pc = 1'b0;
            r.d_bubble = 1'b1;
        end
        return r;
    endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/handshake inputs and enable/bubble/debug outputs of the sequencer
interface pipeline_ctrl_if #(parameter int CNT_WIDTH = 32);
    logic exec_stall, branch_taken, imem_ack, dmem_req, dmem_ack;
    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic d_bubble, e_bubble, m_bubble;
    logic mem_err;
    logic [1:0] ctrl_state;
    logic [CNT_WIDTH-1:0] stall_cycles, flush_count, mem_wait_cycles;
    modport master (
        output exec_stall, branch_taken, imem_ack, dmem_req, dmem_ack,
        input pc_en, fd_en, de_en, em_en, mw_en, d_bubble, e_bubble, m_bubble,
        input mem_err, ctrl_state, stall_cycles, flush_count, mem_wait_cycles
    );
    modport slave (
        input exec_stall, branch_taken, imem_ack, dmem_req, dmem_ack,
        output pc_en, fd_en, de_en, em_en, mw_en, d_bubble, e_bubble, m_bubble,
        output mem_err, ctrl_state, stall_cycles, flush_count, mem_wait_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_wd_timer.sv
// pipe_wd_timer: saturating watchdog counter (load=1, inc, clr) flagging expiry at LIMIT
module pipe_wd_timer #(
    parameter int LIMIT = 16,
    localparam int W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic expired
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : load ? W'(1) : (inc && cnt_q != W'(LIMIT)) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign expired = cnt_q == W'(LIMIT);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage stall/flush sequencer with dmem watchdog; PIPELINE_PERF_CNT_EN adds perf counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input logic clk,
    input logic rst,
    pipeline_ctrl_if.slave bus
);
    pipe_ctrl_state_e state_q, state_d;
    pipe_en_t en, en_o;
    logic t_load, t_inc, t_clr, t_expired;
    pipe_wd_timer #(.LIMIT(MEM_TIMEOUT)) u_wd (
        .clk(clk), .rst(rst), .load(t_load), .inc(t_inc), .clr(t_clr), .expired(t_expired)
    );
    always_comb begin
        state_d = state_q;
        en = EN_FREEZE;
        t_load = 1'b0;
        t_inc = 1'b0;
        t_clr = 1'b0;
        case (state_q)
            RUN:
                if (bus.dmem_req && !bus.dmem_ack) begin
                    state_d = MEM_WAIT;
                    t_load = 1'b1;
                end else en = run_rules(bus.branch_taken, bus.exec_stall, bus.imem_ack);
            MEM_WAIT:
                if (bus.dmem_ack) begin
                    en = run_rules(bus.branch_taken, bus.exec_stall, bus.imem_ack);
                    state_d = RUN;
                    t_clr = 1'b1;
                end else begin
                    t_inc = 1'b1;
                    state_d = t_expired ? HALT : MEM_WAIT;
                end
            HALT: state_d = HALT;
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) state_q <= RUN;
        else state_q <= state_d;
    assign en_o = rst ? EN_RESET : en;
    assign bus.pc_en = en_o.pc;
    assign bus.fd_en = en_o.fd;
    assign bus.de_en = en_o.de;
    assign bus.em_en = en_o.em;
    assign bus.mw_en = en_o.mw;
    assign bus.d_bubble = en_o.d_bubble;
    assign bus.e_bubble = en_o.e_bubble;
    assign bus.m_bubble = en_o.m_bubble;
    assign bus.mem_err = !rst && state_q == HALT;
    assign bus.ctrl_state = rst ? RUN : state_q;
`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d, wait_q, wait_d;
    // Only the branch rule loads the PC while bubbling D.
    always_comb begin
        stall_d = stall_q + CNT_WIDTH'(!en.pc && state_q != HALT && !(&stall_q));
        flush_d = flush_q + CNT_WIDTH'(en.pc && en.d_bubble && !(&flush_q));
        wait_d = wait_q + CNT_WIDTH'(state_q == MEM_WAIT && !(&wait_q));
    end
    always_ff @(posedge clk)
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            wait_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            wait_q <= wait_d;
        end
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count = flush_q;
    assign bus.mem_wait_cycles = wait_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count = '0;
    assign bus.mem_wait_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenario bench for pipeline_ctrl with MEM_TIMEOUT=4
module tb_pipeline_ctrl;
`ifdef PIPELINE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    pipeline_ctrl_if #(.CNT_WIDTH(32)) bus ();
    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    wire [7:0] obs = {bus.pc_en, bus.fd_en, bus.de_en, bus.em_en, bus.mw_en, bus.d_bubble, bus.e_bubble, bus.m_bubble};
    localparam logic [7:0] EN_ALL = 8'b1111_1000;
    localparam logic [7:0] EN_NONE = 8'b0000_0000;
    localparam logic [7:0] EN_RST = 8'b0000_0111;
    localparam logic [7:0] EN_STALL = 8'b0001_1001;
    localparam logic [7:0] EN_BR = 8'b1111_1110;
    localparam logic [7:0] EN_IMISS = 8'b0111_1100;

    task automatic drive(input logic es, input logic bt, input logic ia, input logic dr, input logic da);
        bus.exec_stall = es;
        bus.branch_taken = bt;
        bus.imem_ack = ia;
        bus.dmem_req = dr;
        bus.dmem_ack = da;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 1, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 1, 0, 0);
        tick();
        total++; if (obs !== EN_RST) begin bad++; $display("FAIL rst_en got=%b want=%b", obs, EN_RST); end
        total++; if (bus.ctrl_state !== 2'd0 || bus.mem_err !== 1'b0) begin bad++; $display("FAIL rst_state got=%0d err=%b want=0 0", bus.ctrl_state, bus.mem_err); end
        rst = 1'b0;
        #1;
        total++; if (obs !== EN_ALL) begin bad++; $display("FAIL idle_en got=%b want=%b", obs, EN_ALL); end
        total++; if (bus.ctrl_state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", bus.ctrl_state); end
        total++; if (bus.stall_cycles !== 0 || bus.flush_count !== 0 || bus.mem_wait_cycles !== 0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d/%0d want=0/0/0", bus.stall_cycles, bus.flush_count, bus.mem_wait_cycles); end
    endtask

    task automatic test_exec_stall();
        do_reset();
        drive(1, 0, 1, 0, 0);
        total++; if (obs !== EN_STALL) begin bad++; $display("FAIL stall_en got=%b want=%b", obs, EN_STALL); end
        tick();
        drive(0, 0, 1, 0, 0);
        total++; if (obs !== EN_ALL) begin bad++; $display("FAIL stall_after got=%b want=%b", obs, EN_ALL); end
        total++; if (bus.stall_cycles !== (PERF ? 32'd1 : 32'd0)) begin bad++; $display("FAIL stall_cnt got=%0d want=%0d", bus.stall_cycles, PERF ? 1 : 0); end
        drive(0, 0, 0, 0, 0);
        total++; if (obs !== EN_IMISS) begin bad++; $display("FAIL imiss_en got=%b want=%b", obs, EN_IMISS); end
        tick();
        drive(0, 0, 1, 0, 0);
        total++; if (bus.stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin bad++; $display("FAIL imiss_cnt got=%0d want=%0d", bus.stall_cycles, PERF ? 2 : 0); end
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 1, 1, 0, 0);
        total++; if (obs !== EN_BR) begin bad++; $display("FAIL branch_en got=%b want=%b", obs, EN_BR); end
        tick();
        drive(0, 0, 1, 0, 0);
        total++; if (bus.flush_count !== (PERF ? 32'd1 : 32'd0) || bus.stall_cycles !== 0) begin bad++; $display("FAIL branch_cnt got=%0d/%0d want=%0d/0", bus.flush_count, bus.stall_cycles, PERF ? 1 : 0); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        drive(0, 0, 1, 1, 1);
        total++; if (obs !== EN_ALL) begin bad++; $display("FAIL zw_en got=%b want=%b", obs, EN_ALL); end
        tick();
        drive(0, 0, 1, 0, 0);
        total++; if (bus.ctrl_state !== 2'd0) begin bad++; $display("FAIL zw_state got=%0d want=0", bus.ctrl_state); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        drive(0, 0, 1, 1, 0);
        total++; if (obs !== EN_NONE) begin bad++; $display("FAIL mw_req_en got=%b want=%b", obs, EN_NONE); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            total++; if (obs !== EN_NONE || bus.ctrl_state !== 2'd1) begin bad++; $display("FAIL mw_freeze%0d got=%b st=%0d want=%b st=1", i, obs, bus.ctrl_state, EN_NONE); end
        end
        tick();
        drive(0, 1, 1, 1, 1);
        total++; if (obs !== EN_BR || bus.ctrl_state !== 2'd1) begin bad++; $display("FAIL mw_ack got=%b st=%0d want=%b st=1", obs, bus.ctrl_state, EN_BR); end
        tick();
        drive(0, 0, 1, 0, 0);
        total++; if (bus.ctrl_state !== 2'd0 || bus.mem_err !== 1'b0) begin bad++; $display("FAIL mw_done st=%0d err=%b want=0 0", bus.ctrl_state, bus.mem_err); end
        total++; if (bus.mem_wait_cycles !== (PERF ? 32'd3 : 32'd0) || bus.stall_cycles !== (PERF ? 32'd3 : 32'd0) || bus.flush_count !== (PERF ? 32'd1 : 32'd0)) begin bad++; $display("FAIL mw_cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", bus.mem_wait_cycles, bus.stall_cycles, bus.flush_count, PERF ? 3 : 0, PERF ? 3 : 0, PERF ? 1 : 0); end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(0, 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (bus.ctrl_state !== 2'd1 || bus.mem_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d st=%0d err=%b want=1 0", i, bus.ctrl_state, bus.mem_err); end
        end
        tick();
        total++; if (bus.ctrl_state !== 2'd2 || bus.mem_err !== 1'b1 || obs !== EN_NONE) begin bad++; $display("FAIL to_halt st=%0d err=%b en=%b want=2 1 %b", bus.ctrl_state, bus.mem_err, obs, EN_NONE); end
        drive(0, 1, 1, 1, 1);
        tick();
        tick();
        total++; if (bus.ctrl_state !== 2'd2 || bus.mem_err !== 1'b1 || obs !== EN_NONE) begin bad++; $display("FAIL to_hold st=%0d err=%b en=%b want=2 1 %b", bus.ctrl_state, bus.mem_err, obs, EN_NONE); end
        total++; if (bus.mem_wait_cycles !== (PERF ? 32'd4 : 32'd0) || bus.stall_cycles !== (PERF ? 32'd5 : 32'd0)) begin bad++; $display("FAIL to_cnt got=%0d/%0d want=%0d/%0d", bus.mem_wait_cycles, bus.stall_cycles, PERF ? 4 : 0, PERF ? 5 : 0); end
        rst = 1'b1;
        drive(0, 0, 1, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.ctrl_state !== 2'd0 || bus.mem_err !== 1'b0 || obs !== EN_ALL) begin bad++; $display("FAIL halt_rst st=%0d err=%b en=%b want=0 0 %b", bus.ctrl_state, bus.mem_err, obs, EN_ALL); end
        total++; if (bus.stall_cycles !== 0 || bus.mem_wait_cycles !== 0) begin bad++; $display("FAIL halt_rst_cnt got=%0d/%0d want=0/0", bus.stall_cycles, bus.mem_wait_cycles); end
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        drive(0, 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) tick();
        drive(0, 0, 1, 1, 1);
        total++; if (obs !== EN_ALL || bus.ctrl_state !== 2'd1) begin bad++; $display("FAIL lim_ack got=%b st=%0d want=%b st=1", obs, bus.ctrl_state, EN_ALL); end
        tick();
        drive(0, 0, 1, 0, 0);
        total++; if (bus.ctrl_state !== 2'd0 || bus.mem_err !== 1'b0) begin bad++; $display("FAIL lim_done st=%0d err=%b want=0 0", bus.ctrl_state, bus.mem_err); end
        drive(0, 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) tick();
        total++; if (bus.ctrl_state !== 2'd1) begin bad++; $display("FAIL lim_rearm st=%0d want=1", bus.ctrl_state); end
    endtask

    task automatic test_rst_in_wait();
        do_reset();
        drive(0, 0, 1, 1, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++; if (obs !== EN_RST) begin bad++; $display("FAIL wrst_en got=%b want=%b", obs, EN_RST); end
        tick();
        rst = 1'b0;
        drive(0, 0, 1, 0, 0);
        total++; if (bus.ctrl_state !== 2'd0 || bus.mem_err !== 1'b0 || bus.mem_wait_cycles !== 0 || bus.stall_cycles !== 0) begin bad++; $display("FAIL wrst_state st=%0d err=%b cnt=%0d/%0d want=0 0 0/0", bus.ctrl_state, bus.mem_err, bus.mem_wait_cycles, bus.stall_cycles); end
        total++; if (obs !== EN_ALL) begin bad++; $display("FAIL wrst_idle got=%b want=%b", obs, EN_ALL); end
    endtask

    initial begin
        test_reset();
        test_exec_stall();
        test_branch();
        test_zero_wait();
        test_mem_wait();
        test_timeout();
        test_ack_at_limit();
        test_rst_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W). Consumes the load-use stall from the forwarding unit, the E-stage branch redirect and the instruction/data memory handshakes. Produces PC and pipeline-register load enables plus bubble-insert controls each cycle. Owns the data-memory wait state and a watchdog that halts the core on a hung memory.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before declaring a memory error (>=1)
CNT_WIDTH, 32, width of the optional performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
exec_stall  in  1  load-use hazard from the forwarding unit (E waits on a load in M)
branch_taken  in  1  E-stage redirect; target PC loads when pc_en=1
imem_ack  in  1  fetch data valid this cycle
dmem_req  in  1  valid M-stage load/store is accessing data memory this cycle
dmem_ack  in  1  data memory access completes this cycle
pc_en  out  1  PC register load enable
fd_en, de_en, em_en, mw_en  out  1 each  pipeline-register load enables
d_bubble, e_bubble, m_bubble  out  1 each  when set with matching *_en, load an invalid (NOP) entry into F/D, D/E, E/M
mem_err  out  1  sticky memory-timeout error
ctrl_state  out  2  current state, for debug
stall_cycles, flush_count, mem_wait_cycles  out  CNT_WIDTH each  performance counters

Behaviour:
- State register only; all *_en/*_bubble outputs are combinational from state and inputs (Mealy).
- States (2-bit enum): RUN=0, MEM_WAIT=1, HALT=2.
- While rst=1: all *_en=0, all *_bubble=1, mem_err=0, timer=0, ctrl_state=RUN, counters=0. First cycle after rst deasserts is RUN.
- RUN decision table, first match wins:
  1. dmem_req & ~dmem_ack: all enables 0 (freeze); next MEM_WAIT; timer<=1.
  2. branch_taken: pc_en and all *_en =1; d_bubble=e_bubble=1; exec_stall ignored (D-stage instruction is wrong-path); next RUN.
  3. exec_stall: pc_en=fd_en=de_en=0; em_en=1 with m_bubble=1; mw_en=1; next RUN. Exactly one bubble per assertion.
  4. ~imem_ack: pc_en=0; fd_en=1 with d_bubble=1; de_en=em_en=mw_en=1.
  5. Otherwise: all enables 1, all bubbles 0.
- MEM_WAIT:
  - ~dmem_ack: all enables 0; timer++. If timer==MEM_TIMEOUT, next HALT.
  - dmem_ack: outputs follow RUN rules 2-5 this cycle; next RUN; timer<=0. An ack in the same cycle that the timer reaches its limit wins; no error.
- HALT: all enables 0, all bubbles 0, mem_err=1. Only rst exits HALT.
- dmem_req & dmem_ack in the same RUN cycle is a zero-wait access: no MEM_WAIT entry.
- Timer width is $clog2(MEM_TIMEOUT+1) and never wraps.

Optional Feature:
PIPELINE_PERF_CNT_EN
- Defined: three saturating counters, each reset to 0.
  - stall_cycles: +1 on each cycle with pc_en=0 outside HALT.
  - flush_count: +1 per accepted branch_taken.
  - mem_wait_cycles: +1 on each cycle in MEM_WAIT.
  - All hold at the all-ones value.
- Not defined: the counter ports remain and are tied to 0; no counter flops are built.

Decomposition:
- structs package: add pipe_ctrl_state_e enum (RUN/MEM_WAIT/HALT) and a pipe_en_t packed struct bundling pc/fd/de/em/mw enables and d/e/m bubbles.
- One natural sub-module: pipe_wd_timer (load/increment/clear, expired flag at MEM_TIMEOUT), reused later for the fetch side.

Test Plan:
- Reset then idle with imem_ack=1: all enables 1, bubbles 0, ctrl_state=0 on first post-reset cycle. With rst held high: enables 0, bubbles 1.
- exec_stall=1 for one cycle: pc_en=fd_en=de_en=0, em_en=1, m_bubble=1; next cycle all enables 1. stall_cycles=1 with macro defined.
- branch_taken=1 together with exec_stall=1: pc_en=1, d_bubble=e_bubble=1, m_bubble=0; flush_count increments by 1.
- dmem_req=1, dmem_ack arriving 3 cycles later: 3 freeze cycles in MEM_WAIT, then ack cycle with all enables 1; mem_wait_cycles=3; mem_err stays 0.
- MEM_TIMEOUT=4, dmem_req with no ack: HALT after 4 MEM_WAIT cycles, mem_err=1 held; ack arriving on the 4th cycle instead returns to RUN with no error.
- Assert rst during MEM_WAIT and during HALT: next cycle ctrl_state=RUN, mem_err=0, counters 0.
